mm_stream_ctrl: RTL and testbench
=================================

// Module: mm_stream_ctrl
// PURPOSE
//  Stream-side sequencer for the matrix-multiply core. Accepts A (MxN) then B (NxP) words on a
//  valid/ready slave stream and writes them into the A/B RAMs. It then runs the core with a
//  held-Start/Done handshake and streams the MxP result from the RES RAM on a master stream.
//  Sits between the DMA stream wrapper and the core plus its three RAMs.
// PARAMETERS
//  width          8   data bits per word (stream and RAM)
//  A_depth_bits   9   A RAM address bits; M*N <= 2**A_depth_bits
//  B_depth_bits   9   B RAM address bits; N*P <= 2**B_depth_bits
//  RES_depth_bits 9   RES RAM address bits; M*P <= 2**RES_depth_bits
//  M 64 / N 8 / P 2   matrix dimensions: A is MxN, B is NxP, RES is MxP
// PORTS
//  clk            in  1      clock, all logic on posedge
//  resetn         in  1      synchronous reset, active low
//  s_tdata        in  width  input word, A row-major then B row-major
//  s_tvalid       in  1      input word valid
//  s_tready       out 1      controller can accept a word
//  s_tlast        in  1      marks the final B word
//  m_tdata        out width  result word, row-major
//  m_tvalid       out 1      result valid
//  m_tready       in  1      downstream accepts
//  m_tlast        out 1      high with result word M*P-1
//  A_write_en/A_write_address[A_depth_bits]/A_write_data_in[width]        out  A RAM write port
//  B_write_en/B_write_address[B_depth_bits]/B_write_data_in[width]        out  B RAM write port
//  RES_read_en    out 1      RES RAM read enable; data returns 1 cycle later
//  RES_read_address out RES_depth_bits
//  RES_read_data_out in width
//  mm_start       out 1      to core Start; held high until mm_done is sampled
//  mm_done        in  1      from core Done
//  err_tlast      out 1      sticky: s_tlast was misplaced
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE. Outputs s_tready, m_tvalid, m_tlast, all *_en,
//   mm_start and err_tlast =0; addresses and m_tdata =0. Counters cleared. Reset applies
//   from any state and abandons any transfer in progress.
//  States: IDLE -> LOAD_A -> LOAD_B -> RUN -> DRAIN -> IDLE.
//  IDLE: s_tready=0. Moves to LOAD_A on the next cycle (one cycle of idle after each frame).
//  LOAD_A: s_tready=1. On each handshake (s_tvalid&s_tready), registered write to A:
//   A_write_en=1 for one cycle, address = word count 0..M*N-1.
//   After word M*N-1, go to LOAD_B.
//  LOAD_B: same rule into the B RAM, addresses 0..N*P-1. After word N*P-1, go to RUN.
//   s_tready drops in the cycle after the last accepted word.
//  s_tlast: expected only with B word N*P-1. If s_tlast is seen on any other accepted word,
//   or is missing on that word, set err_tlast. err_tlast clears only on reset.
//   Word counts are never truncated or extended because of s_tlast.
//  RUN: mm_start=1 from entry and held. When mm_done=1 is sampled, drop mm_start to 0 in the
//   same edge (the core returns to its idle/clear path) and go to DRAIN.
//   mm_done is ignored while in any other state.
//  DRAIN: read RES addresses 0..M*P-1 with 1-cycle read latency, through a 2-entry
//   skid buffer, so that m_tvalid/m_tdata stay stable while m_tready=0.
//   A read is issued only if a skid slot will be free.
//   Zero-bubble throughput when m_tready=1 continuously: one word per cycle after a 2-cycle
//   fill. m_tlast=1 only with word M*P-1. After that word's handshake, go to IDLE.
//  Once m_tvalid is high it must not drop before the handshake (AXI-stream rule).
//  Counters are sized $clog2(depth)+1 bits; no wrap within a frame.
//  Address = counter, truncated to the RAM address width.
// CONFIGURATION
//  `MM_CYC_CNT_EN defined: adds output cyc_count[31:0]. It counts clk cycles spent in RUN,
//   clears on entry to RUN, holds in other states, resets to 0, and saturates at 2**32-1.
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  Shared package mm_pkg: state localparams (IDLE, LOAD_A, LOAD_B, RUN, DRAIN, one-hot 5 bit)
//   and the M/N/P defaults and derived word counts (A_WORDS=M*N, B_WORDS=N*P, RES_WORDS=M*P).
//  Sub-module: mm_out_skid, a 2-entry valid/ready skid buffer on the RES read path.
// TESTING
//  1 Reset: resetn=0 for 3 cycles mid-LOAD_A -> all outputs 0, state=IDLE. Next load starts at
//    A address 0.
//  2 Load: 512 A words (value=addr[7:0]) + 16 B words, s_tvalid always 1 -> 512 A writes at
//    0..511, 16 B writes at 0..15. mm_start rises the cycle after B word 15.
//  3 Handshake: stub holds mm_done=0 for 100 cycles then 1 -> mm_start falls at the same edge.
//    The first RES_read_en follows within 1 cycle.
//  4 Drain backpressure: m_tready toggles 1,0,0,1 repeatedly -> 128 words in address order,
//    none lost or duplicated. m_tlast only on the 128th word, m_tdata stable while stalled.
//  5 tlast error: s_tlast on A word 10 -> err_tlast=1 from the next cycle. Frame still
//    completes with 128 outputs.
//  6 Throughput: m_tready=1 continuously -> 128 consecutive valid cycles, no gaps;
//    with `MM_CYC_CNT_EN, cyc_count=100-cycle stub latency (+/-1).

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mm_pkg
//  Purpose : Shared definitions for the matrix-multiply stream sequencer:
//            one-hot controller state encoding, default matrix dimensions
//            and the derived per-frame word counts.
//  Ports   : none (package)
//  Config  : none
//  Revision: 1.0 - initial release
// ============================================================================
package mm_pkg;

    // Default matrix dimensions: A is MxN, B is NxP, RES is MxP.
    localparam int DEF_M = 64;
    localparam int DEF_N = 8;
    localparam int DEF_P = 2;

    // Words per frame for each matrix at the default dimensions.
    localparam int A_WORDS   = DEF_M * DEF_N;
    localparam int B_WORDS   = DEF_N * DEF_P;
    localparam int RES_WORDS = DEF_M * DEF_P;

    // Controller states, one-hot, 5 bits.
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        LOAD_A = 5'b00010,
        LOAD_B = 5'b00100,
        RUN    = 5'b01000,
        DRAIN  = 5'b10000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mm_out_skid.sv
`default_nettype none
// ============================================================================
//  Module  : mm_out_skid
//  Purpose : Two-entry valid/ready skid buffer for the RES read path. The
//            head entry drives the output directly from registers, so the
//            presented word stays stable while the consumer stalls.
//  Ports   : clk, resetn           clock / synchronous active-low reset
//            in_valid/data/last    word returning from the RES RAM
//            out_valid/data/last   head of buffer toward the master stream
//            out_ready             consumer accepts the head word
//            count[1:0]            current occupancy (0..2)
//  Config  : none
//  Revision: 1.0 - initial release
// ============================================================================
module mm_out_skid #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [width-1:0] r_data0;
    logic [width-1:0] r_data1;
    logic             r_last0;
    logic             r_last1;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign w_pop     = (r_cnt != 2'd0) & out_ready;
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_data0;
    assign out_last  = r_last0;
    assign count     = r_cnt;

    // Slot 0 is always the head. The producer never pushes into a full
    // buffer, because it reserves space before issuing a read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_cnt   <= 2'd0;
        end else begin
            case ({in_valid, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_data0 <= in_data;
                        r_last0 <= in_last;
                    end else begin
                        r_data1 <= in_data;
                        r_last1 <= in_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_data0 <= in_data;
                        r_last0 <= in_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= in_data;
                        r_last1 <= in_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mm_stream_ctrl
//  Purpose : Stream-side sequencer for the matrix-multiply core. Loads A
//            (MxN) then B (NxP) from a valid/ready slave stream into the A/B
//            RAMs, runs the core with a held Start/Done handshake, then
//            streams the MxP result out of the RES RAM on a master stream.
//  Ports   : clk, resetn                      clock / sync active-low reset
//            s_tdata/s_tvalid/s_tready/s_tlast input stream
//            m_tdata/m_tvalid/m_tready/m_tlast result stream
//            A_write_*, B_write_*              RAM write ports
//            RES_read_en/address/data_out      RES RAM read port (1-cycle)
//            mm_start, mm_done                 core handshake
//            err_tlast                         sticky misplaced-tlast flag
//            cyc_count[31:0]                   RUN cycle count (optional)
//  Config  : MM_CYC_CNT_EN - when defined, adds cyc_count.
//  Revision: 1.0 - initial release
// ============================================================================
module mm_stream_ctrl
    import mm_pkg::*;
#(
    parameter int width          = 8,
    parameter int A_depth_bits   = 9,
    parameter int B_depth_bits   = 9,
    parameter int RES_depth_bits = 9,
    parameter int M              = DEF_M,
    parameter int N              = DEF_N,
    parameter int P              = DEF_P
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [width-1:0]          s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic                      s_tlast,
    output logic [width-1:0]          m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,
    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out,
    output logic                      mm_start,
    input  logic                      mm_done,
`ifdef MM_CYC_CNT_EN
    output logic [31:0]               cyc_count,
`endif
    output logic                      err_tlast
);

    localparam int c_A_WORDS   = M * N;
    localparam int c_B_WORDS   = N * P;
    localparam int c_RES_WORDS = M * P;
    localparam int c_A_CW      = A_depth_bits + 1;
    localparam int c_B_CW      = B_depth_bits + 1;
    localparam int c_R_CW      = RES_depth_bits + 1;

    localparam logic [c_A_CW-1:0] c_A_LAST  = c_A_CW'(c_A_WORDS - 1);
    localparam logic [c_B_CW-1:0] c_B_LAST  = c_B_CW'(c_B_WORDS - 1);
    localparam logic [c_R_CW-1:0] c_R_LAST  = c_R_CW'(c_RES_WORDS - 1);
    localparam logic [c_R_CW-1:0] c_R_WORDS = c_R_CW'(c_RES_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic [c_A_CW-1:0] r_a_cnt;
    logic [c_B_CW-1:0] r_b_cnt;
    logic [c_R_CW-1:0] r_rd_cnt;
    logic              r_pend;        // read issued last cycle, data on RES bus now
    logic              r_pend_last;   // that read was for the final RES word
    logic [1:0]        w_occ;
    logic              w_pop;
    logic              w_room;
    logic              w_a_last;
    logic              w_b_last;

    assign w_a_last = (r_a_cnt == c_A_LAST);
    assign w_b_last = (r_b_cnt == c_B_LAST);
    assign w_pop    = m_tvalid & m_tready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        s_tready = 1'b0;
        mm_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = LOAD_A;
            end
            LOAD_A: begin
                s_tready = 1'b1;
                if (s_tvalid && w_a_last) begin
                    w_next = LOAD_B;
                end
            end
            LOAD_B: begin
                s_tready = 1'b1;
                if (s_tvalid && w_b_last) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                // Start is held for the whole RUN state and drops on the
                // same edge that samples Done.
                mm_start = 1'b1;
                if (mm_done) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && m_tlast) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RES read issue. A read lands in the skid one cycle later, so the
    // slot it needs must be free even if nothing pops in the meantime:
    // words held plus words in flight, minus this cycle's pop, must leave
    // room for one more.
    // ------------------------------------------------------------------
    assign w_room = ({1'b0, w_occ} + {2'b00, r_pend}) <= (3'd1 + {2'b00, w_pop});

    assign RES_read_en      = (r_state == DRAIN) && (r_rd_cnt < c_R_WORDS) && w_room;
    assign RES_read_address = r_rd_cnt[RES_depth_bits-1:0];

    // ------------------------------------------------------------------
    // Load datapath, tlast checking, read counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a_cnt         <= '0;
            r_b_cnt         <= '0;
            r_rd_cnt        <= '0;
            r_pend          <= 1'b0;
            r_pend_last     <= 1'b0;
            A_write_en      <= 1'b0;
            A_write_address <= '0;
            A_write_data_in <= '0;
            B_write_en      <= 1'b0;
            B_write_address <= '0;
            B_write_data_in <= '0;
            err_tlast       <= 1'b0;
        end else begin
            A_write_en  <= 1'b0;
            B_write_en  <= 1'b0;
            r_pend      <= RES_read_en;
            r_pend_last <= RES_read_en && (r_rd_cnt == c_R_LAST);

            if (r_state == IDLE) begin
                r_a_cnt  <= '0;
                r_b_cnt  <= '0;
                r_rd_cnt <= '0;
            end

            // s_tready is high throughout both load states, so s_tvalid
            // alone marks a handshake there.
            if (r_state == LOAD_A && s_tvalid) begin
                A_write_en      <= 1'b1;
                A_write_address <= r_a_cnt[A_depth_bits-1:0];
                A_write_data_in <= s_tdata;
                r_a_cnt         <= r_a_cnt + 1'b1;
                if (s_tlast) begin
                    err_tlast <= 1'b1;
                end
            end

            if (r_state == LOAD_B && s_tvalid) begin
                B_write_en      <= 1'b1;
                B_write_address <= r_b_cnt[B_depth_bits-1:0];
                B_write_data_in <= s_tdata;
                r_b_cnt         <= r_b_cnt + 1'b1;
                if (s_tlast != w_b_last) begin
                    err_tlast <= 1'b1;
                end
            end

            if (RES_read_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output skid buffer
    // ------------------------------------------------------------------
    mm_out_skid #(
        .width (width)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (r_pend),
        .in_data   (RES_read_data_out),
        .in_last   (r_pend_last),
        .out_valid (m_tvalid),
        .out_data  (m_tdata),
        .out_last  (m_tlast),
        .out_ready (m_tready),
        .count     (w_occ)
    );

`ifdef MM_CYC_CNT_EN
    // ------------------------------------------------------------------
    // RUN-state cycle counter: cleared on entry, saturating, held outside RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cyc_count <= 32'd0;
        end else if (r_state != RUN && w_next == RUN) begin
            cyc_count <= 32'd0;
        end else if (r_state == RUN && cyc_count != 32'hFFFF_FFFF) begin
            cyc_count <= cyc_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mm_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mm_stream_ctrl
//  Purpose : Self-checking bench for mm_stream_ctrl. Drivers push expected
//            RAM writes and result words into queues; monitors pop and
//            compare whenever the DUT presents a write or an output word.
//  Config  : MM_CYC_CNT_EN - also checks cyc_count.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mm_stream_ctrl;
    import mm_pkg::*;

    localparam int AW = A_WORDS;
    localparam int BW = B_WORDS;
    localparam int RW = RES_WORDS;

    logic       clk;
    logic       resetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic       A_write_en;
    logic [8:0] A_write_address;
    logic [7:0] A_write_data_in;
    logic       B_write_en;
    logic [8:0] B_write_address;
    logic [7:0] B_write_data_in;
    logic       RES_read_en;
    logic [8:0] RES_read_address;
    logic [7:0] RES_read_data_out;
    logic       mm_start;
    logic       mm_done;
    logic       err_tlast;
`ifdef MM_CYC_CNT_EN
    logic [31:0] cyc_count;
`endif

    mm_stream_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .s_tdata           (s_tdata),
        .s_tvalid          (s_tvalid),
        .s_tready          (s_tready),
        .s_tlast           (s_tlast),
        .m_tdata           (m_tdata),
        .m_tvalid          (m_tvalid),
        .m_tready          (m_tready),
        .m_tlast           (m_tlast),
        .A_write_en        (A_write_en),
        .A_write_address   (A_write_address),
        .A_write_data_in   (A_write_data_in),
        .B_write_en        (B_write_en),
        .B_write_address   (B_write_address),
        .B_write_data_in   (B_write_data_in),
        .RES_read_en       (RES_read_en),
        .RES_read_address  (RES_read_address),
        .RES_read_data_out (RES_read_data_out),
        .mm_start          (mm_start),
        .mm_done           (mm_done),
`ifdef MM_CYC_CNT_EN
        .cyc_count         (cyc_count),
`endif
        .err_tlast         (err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: {address, data} for RAM writes, {last, data} for results.
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [8:0]  qr[$];

    // RES RAM model with one-cycle read latency.
    logic [7:0] res_mem [0:511];
    logic [7:0] res_q = 8'h00;
    always @(posedge clk) begin
        if (RES_read_en) res_q <= res_mem[RES_read_address];
    end
    assign RES_read_data_out = res_q;

    // Downstream ready generator: 0 = pattern 1,0,0,1; 1 = always; 2 = random.
    int rmode  = 1;
    int rphase = 0;
    initial begin
        m_tready = 1'b0;
        forever begin
            @(negedge clk);
            case (rmode)
                0: begin
                    m_tready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
                    rphase++;
                end
                1: m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Core stub: holds Done low for stub_lat cycles after Start, then pulses it.
    int stub_lat = 100;
    initial begin
        mm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && mm_start) begin
                repeat (stub_lat) @(negedge clk);
                mm_done = 1'b1;
                @(negedge clk);
                #1;
                chk("mm_start_fall_on_done", 64'(mm_start), 64'd0);
                chk("res_read_after_done", 64'(RES_read_en), 64'd1);
                mm_done = 1'b0;
            end
        end
    end

    // Monitor: RAM writes and result stream.
    int         out_cnt    = 0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_word  = 9'h0;
    initial begin
        logic [16:0] e17;
        logic [8:0]  e9;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (A_write_en) begin
                    if (qa.size() == 0) chk("a_write_unexpected", 64'd1, 64'd0);
                    else begin
                        e17 = qa.pop_front();
                        chk("a_write", 64'({A_write_address, A_write_data_in}), 64'(e17));
                    end
                end
                if (B_write_en) begin
                    if (qb.size() == 0) chk("b_write_unexpected", 64'd1, 64'd0);
                    else begin
                        e17 = qb.pop_front();
                        chk("b_write", 64'({B_write_address, B_write_data_in}), 64'(e17));
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid_held", 64'(m_tvalid), 64'd1);
                    chk("stall_word_stable", 64'({m_tlast, m_tdata}), 64'(prev_word));
                end
                if (m_tvalid && m_tready) begin
                    if (qr.size() == 0) chk("result_unexpected", 64'd1, 64'd0);
                    else begin
                        e9 = qr.pop_front();
                        chk("result_word", 64'({m_tlast, m_tdata}), 64'(e9));
                    end
                    out_cnt++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_word  = {m_tlast, m_tdata};
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
        chk({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
        chk({tag, "_wr_en"}, 64'({A_write_en, B_write_en, RES_read_en}), 64'd0);
        chk({tag, "_addr"}, 64'({A_write_address, B_write_address, RES_read_address}), 64'd0);
        chk({tag, "_mm_start"}, 64'(mm_start), 64'd0);
        chk({tag, "_err_tlast"}, 64'(err_tlast), 64'd0);
    endtask

    // One complete frame: load A and B, run, drain.
    task automatic run_frame(input bit rand_valid, input bit a_is_addr, input int rm,
                             input int lat, input int err_idx, input bit thru);
        logic [7:0] wdata [0:AW+BW-1];
        int  i      = 0;
        int  guard  = 0;
        int  gaps   = 0;
        bit  exp_err = 1'b0;
        bit  err_pend = 1'b0;
        bit  last;
        for (int k = 0; k < RW; k++) res_mem[k] = 8'($urandom);
        for (int k = 0; k < AW + BW; k++)
            wdata[k] = (a_is_addr && k < AW) ? 8'(k) : 8'($urandom);
        rmode    = rm;
        rphase   = 0;
        stub_lat = lat;
        out_cnt  = 0;
        while (i < AW + BW && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (err_pend) begin
                chk("err_tlast_next_cycle", 64'(err_tlast), 64'd1);
                err_pend = 1'b0;
            end
            if (rand_valid && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'($urandom_range(0, 1));
            end else begin
                last     = (i == AW + BW - 1) || (i == err_idx);
                s_tvalid = 1'b1;
                s_tdata  = wdata[i];
                s_tlast  = last;
                if (s_tready) begin
                    if (last != (i == AW + BW - 1)) exp_err = 1'b1;
                    if (i < AW) qa.push_back({9'(i), wdata[i]});
                    else        qb.push_back({9'(i - AW), wdata[i]});
                    if (i == err_idx) err_pend = 1'b1;
                    i++;
                end
            end
        end
        if (i < AW + BW) chk("load_timeout", 64'(i), 64'(AW + BW));
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("mm_start_after_last_b", 64'(mm_start), 64'd1);
        chk("s_tready_drop", 64'(s_tready), 64'd0);
        for (int k = 0; k < RW; k++) qr.push_back({(k == RW - 1), res_mem[k]});
        if (thru) begin
            #1;
            guard = 0;
            while (!m_tvalid && guard < lat + 50) begin
                @(negedge clk);
                #1;
                guard++;
            end
            for (int k = 0; k < RW; k++) begin
                if (!m_tvalid) gaps++;
                @(negedge clk);
                #1;
            end
            chk("throughput_gaps", 64'(gaps), 64'd0);
        end
        guard = 0;
        while (out_cnt < RW && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk("frame_output_count", 64'(out_cnt), 64'(RW));
        chk("result_queue_empty", 64'(qr.size()), 64'd0);
        chk("err_tlast_frame_end", 64'(err_tlast), 64'(exp_err));
`ifdef MM_CYC_CNT_EN
        chk("cyc_count_window", 64'((cyc_count + 1 >= 32'(lat)) && (cyc_count <= 32'(lat + 1))), 64'd1);
`endif
    endtask

    initial begin
        int cnt;
        int guard;
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_initial");
        resetn = 1'b1;

        // Partial A load, then reset in the middle of it.
        cnt = 0;
        guard = 0;
        while (cnt < 20 && guard < 100) begin
            @(negedge clk);
            guard++;
            s_tvalid = 1'b1;
            s_tdata  = 8'($urandom);
            if (s_tready) begin
                qa.push_back({9'(cnt), s_tdata});
                cnt++;
            end
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("partial_writes_seen", 64'(qa.size()), 64'd0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_mid_load");
        qa.delete();
        resetn = 1'b1;

        run_frame(1'b0, 1'b1, 0, 100, -1, 1'b0);
        run_frame(1'b1, 1'b0, 2, int'($urandom_range(3, 40)), -1, 1'b0);
        run_frame(1'b0, 1'b0, 1, 100, -1, 1'b1);
        run_frame(1'b1, 1'b0, 2, 20, 10, 1'b0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
